sprite_bouncer: RTL and testbench

- Per-frame motion engine for the LCD sprite overlay.
- Consumes the `frame_int` pulse produced by the LCD timing block and computes bouncing sprite offsets.
- Its `offset_x`/`offset_y` outputs drive the overlay position inputs of the LCD pipeline.
- Velocity is runtime-configurable from a control source, e.g. a future UART command decoder.

---
 rtl/sprite_bouncer.sv | 229 ++++++++++++++++++++++
 tb/tb_sprite_bouncer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_bouncer.sv
// Per-frame bouncing sprite motion engine: detects frame_int edges and steps
// the overlay offsets by a runtime-configurable velocity, reflecting off the screen walls.
module sprite_bouncer #(
    parameter int SCREEN_W = 800,
    parameter int SCREEN_H = 480,
    parameter int SPRITE_W = 64,
    parameter int SPRITE_H = 64,
    parameter int INIT_X   = 123,
    parameter int INIT_Y   = 234,
    parameter int INIT_DX  = 1,
    parameter int INIT_DY  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_int,
    input  logic        enable,
    input  logic        cfg_we,
    input  logic [7:0]  cfg_dx,
    input  logic [7:0]  cfg_dy,
    output logic [15:0] offset_x,
    output logic [15:0] offset_y,
    output logic        update_done,
    output logic        bounce_x,
    output logic        bounce_y,
    output logic        overrun,
    output logic [15:0] frame_count
);

    localparam logic signed [16:0] MAX_X = 17'(SCREEN_W - SPRITE_W);
    localparam logic signed [16:0] MAX_Y = 17'(SCREEN_H - SPRITE_H);

    typedef enum logic [1:0] {
        IDLE,
        CALC_X,
        CALC_Y,
        COMMIT
    } state_t;

    typedef struct packed {
        logic signed [16:0] pos;
        logic signed [7:0]  vel;
        logic               hit;
    } refl_t;

    // One axis step: move, then mirror about whichever wall was reached or crossed.
    function automatic refl_t reflect(input logic signed [16:0] pos,
                                      input logic signed [7:0]  vel,
                                      input logic signed [16:0] max_pos);
        refl_t              r;
        logic signed [16:0] np;
        logic               wall;
        np    = pos + {{9{vel[7]}}, vel};
        r.pos = np;
        r.vel = vel;
        r.hit = 1'b0;
        wall  = 1'b0;
        if (np <= 17'sd0) begin
            r.pos = -np;
            wall  = 1'b1;
        end else if (np >= max_pos) begin
            r.pos = (max_pos + max_pos) - np;
            wall  = 1'b1;
        end
        if (wall && (vel != 8'sd0)) begin
            r.vel = -vel;
            r.hit = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [7:0] clamp_vel(input logic [7:0] v);
        return (v == 8'h80) ? 8'h81 : v;
    endfunction

    state_t             state_q, state_d;
    logic               frame_int_q, frame_int_d;
    logic [15:0]        frame_count_q, frame_count_d;
    logic               pend_valid_q, pend_valid_d;
    logic [7:0]         pend_dx_q, pend_dx_d;
    logic [7:0]         pend_dy_q, pend_dy_d;
    logic signed [7:0]  dx_q, dx_d;
    logic signed [7:0]  dy_q, dy_d;
    logic signed [16:0] wx_q, wx_d;
    logic signed [16:0] wy_q, wy_d;
    logic signed [7:0]  wdx_q, wdx_d;
    logic signed [7:0]  wdy_q, wdy_d;
    logic               bx_q, bx_d;
    logic [15:0]        offset_x_q, offset_x_d;
    logic [15:0]        offset_y_q, offset_y_d;
    logic               update_done_q, update_done_d;
    logic               bounce_x_q, bounce_x_d;
    logic               bounce_y_q, bounce_y_d;

    logic               frame_edge;
    logic [7:0]         cfg_dx_c, cfg_dy_c;
    logic signed [7:0]  vel_dx, vel_dy;
    refl_t              rx, ry;

    assign frame_edge = frame_int & ~frame_int_q;
    assign cfg_dx_c   = clamp_vel(cfg_dx);
    assign cfg_dy_c   = clamp_vel(cfg_dy);

    always_comb begin
        state_d       = state_q;
        frame_int_d   = frame_int;
        frame_count_d = frame_count_q;
        pend_valid_d  = pend_valid_q;
        pend_dx_d     = pend_dx_q;
        pend_dy_d     = pend_dy_q;
        dx_d          = dx_q;
        dy_d          = dy_q;
        wx_d          = wx_q;
        wy_d          = wy_q;
        wdx_d         = wdx_q;
        wdy_d         = wdy_q;
        bx_d          = bx_q;
        offset_x_d    = offset_x_q;
        offset_y_d    = offset_y_q;
        update_done_d = 1'b0;
        bounce_x_d    = 1'b0;
        bounce_y_d    = 1'b0;

        // A same-cycle strobe wins over an older pending value, which wins over the current velocity.
        vel_dx = cfg_we ? cfg_dx_c : (pend_valid_q ? pend_dx_q : dx_q);
        vel_dy = cfg_we ? cfg_dy_c : (pend_valid_q ? pend_dy_q : dy_q);
        rx     = reflect(wx_q, wdx_q, MAX_X);
        ry     = reflect(wy_q, wdy_q, MAX_Y);

        if (frame_edge) begin
            frame_count_d = frame_count_q + 16'd1;
        end
        if (cfg_we) begin
            pend_dx_d    = cfg_dx_c;
            pend_dy_d    = cfg_dy_c;
            pend_valid_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                dx_d         = vel_dx;
                dy_d         = vel_dy;
                pend_valid_d = 1'b0;
                if (frame_edge && enable) begin
                    wx_d    = {offset_x_q[15], offset_x_q};
                    wy_d    = {offset_y_q[15], offset_y_q};
                    wdx_d   = vel_dx;
                    wdy_d   = vel_dy;
                    state_d = CALC_X;
                end
            end
            CALC_X: begin
                wx_d    = rx.pos;
                wdx_d   = rx.vel;
                bx_d    = rx.hit;
                state_d = CALC_Y;
            end
            CALC_Y: begin
                // Registering the commit here makes the offsets visible during COMMIT.
                wy_d          = ry.pos;
                wdy_d         = ry.vel;
                offset_x_d    = wx_q[15:0];
                offset_y_d    = ry.pos[15:0];
                dx_d          = wdx_q;
                dy_d          = ry.vel;
                update_done_d = 1'b1;
                bounce_x_d    = bx_q;
                bounce_y_d    = ry.hit;
                state_d       = COMMIT;
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            frame_int_q   <= 1'b0;
            frame_count_q <= '0;
            pend_valid_q  <= 1'b0;
            pend_dx_q     <= '0;
            pend_dy_q     <= '0;
            dx_q          <= 8'(INIT_DX);
            dy_q          <= 8'(INIT_DY);
            wx_q          <= '0;
            wy_q          <= '0;
            wdx_q         <= '0;
            wdy_q         <= '0;
            bx_q          <= 1'b0;
            offset_x_q    <= 16'(INIT_X);
            offset_y_q    <= 16'(INIT_Y);
            update_done_q <= 1'b0;
            bounce_x_q    <= 1'b0;
            bounce_y_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_int_q   <= frame_int_d;
            frame_count_q <= frame_count_d;
            pend_valid_q  <= pend_valid_d;
            pend_dx_q     <= pend_dx_d;
            pend_dy_q     <= pend_dy_d;
            dx_q          <= dx_d;
            dy_q          <= dy_d;
            wx_q          <= wx_d;
            wy_q          <= wy_d;
            wdx_q         <= wdx_d;
            wdy_q         <= wdy_d;
            bx_q          <= bx_d;
            offset_x_q    <= offset_x_d;
            offset_y_q    <= offset_y_d;
            update_done_q <= update_done_d;
            bounce_x_q    <= bounce_x_d;
            bounce_y_q    <= bounce_y_d;
        end
    end

    assign offset_x    = offset_x_q;
    assign offset_y    = offset_y_q;
    assign update_done = update_done_q;
    assign bounce_x    = bounce_x_q;
    assign bounce_y    = bounce_y_q;
    assign frame_count = frame_count_q;
    assign overrun     = frame_edge && (state_q != IDLE);

endmodule

// File: tb/tb_sprite_bouncer.sv
// Scoreboard bench for sprite_bouncer: three instances (default, right-wall and
// left-wall start positions) share control inputs but have private frame/cfg strobes.
module tb_sprite_bouncer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  cfg_dx, cfg_dy;
    logic        fi  [3];
    logic        cwe [3];
    logic [15:0] ox  [3];
    logic [15:0] oy  [3];
    logic [15:0] fc  [3];
    logic        ud  [3];
    logic        bxo [3];
    logic        byo [3];
    logic        ovr [3];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int inst;
        int x;
        int y;
        int bx;
        int by;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sprite_bouncer dut0 (
        .clk(clk), .reset(reset), .frame_int(fi[0]), .enable(enable),
        .cfg_we(cwe[0]), .cfg_dx(cfg_dx), .cfg_dy(cfg_dy),
        .offset_x(ox[0]), .offset_y(oy[0]), .update_done(ud[0]),
        .bounce_x(bxo[0]), .bounce_y(byo[0]), .overrun(ovr[0]), .frame_count(fc[0])
    );

    sprite_bouncer #(.INIT_X(735)) dut1 (
        .clk(clk), .reset(reset), .frame_int(fi[1]), .enable(enable),
        .cfg_we(cwe[1]), .cfg_dx(cfg_dx), .cfg_dy(cfg_dy),
        .offset_x(ox[1]), .offset_y(oy[1]), .update_done(ud[1]),
        .bounce_x(bxo[1]), .bounce_y(byo[1]), .overrun(ovr[1]), .frame_count(fc[1])
    );

    sprite_bouncer #(.INIT_X(1)) dut2 (
        .clk(clk), .reset(reset), .frame_int(fi[2]), .enable(enable),
        .cfg_we(cwe[2]), .cfg_dx(cfg_dx), .cfg_dy(cfg_dy),
        .offset_x(ox[2]), .offset_y(oy[2]), .update_done(ud[2]),
        .bounce_x(bxo[2]), .bounce_y(byo[2]), .overrun(ovr[2]), .frame_count(fc[2])
    );

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitor: every update_done pulse must match the oldest expected commit.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ud[i] === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_update: inst %0d got x=%0d y=%0d, expected no update",
                             i, ox[i], oy[i]);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("upd_inst",  i,            mon_e.inst);
                    chk("upd_x",     int'(ox[i]),  mon_e.x);
                    chk("upd_y",     int'(oy[i]),  mon_e.y);
                    chk("upd_bx",    int'(bxo[i]), mon_e.bx);
                    chk("upd_by",    int'(byo[i]), mon_e.by);
                    chk("upd_cycle", cyc,          mon_e.cyc);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fi[i]  = 1'b0;
            cwe[i] = 1'b0;
        end
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic cfg(input int i, input logic [7:0] dx, input logic [7:0] dy);
        cfg_dx = dx;
        cfg_dy = dy;
        cwe[i] = 1'b1;
        step();
        cwe[i] = 1'b0;
    endtask

    // Raise frame_int for 'hold' cycles; an expected commit lands 3 cycles after the edge.
    task automatic fire(input int i, input int hold, input bit push,
                        input int x, input int y, input int bx, input int by);
        if (push) exp_q.push_back('{i, x, y, bx, by, cyc + 3});
        fi[i] = 1'b1;
        repeat (hold) step();
        fi[i] = 1'b0;
    endtask

    task automatic drain();
        repeat (6) step();
        chk("commits_seen", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        cfg_dx = '0;
        cfg_dy = '0;
        for (int i = 0; i < 3; i++) begin
            fi[i]  = 1'b0;
            cwe[i] = 1'b0;
        end

        // Reset state and two plain updates
        do_reset();
        chk("rst_x",   int'(ox[0]),  123);
        chk("rst_y",   int'(oy[0]),  234);
        chk("rst_fc",  int'(fc[0]),  0);
        chk("rst_ud",  int'(ud[0]),  0);
        chk("rst_ovr", int'(ovr[0]), 0);
        fire(0, 1, 1, 124, 235, 0, 0);
        drain();
        fire(0, 1, 1, 125, 236, 0, 0);
        drain();
        chk("fc_two_edges", int'(fc[0]), 2);

        // Right wall: 735+3=738 -> 2*736-738 = 734, then 734-3 = 731
        do_reset();
        cfg(1, 8'd3, 8'd1);
        fire(1, 1, 1, 734, 235, 1, 0);
        drain();
        fire(1, 1, 1, 731, 236, 0, 0);
        drain();

        // Left wall: 1-3=-2 -> 2 with dx flipped to +3, then 5
        do_reset();
        cfg(2, 8'hFD, 8'd1);
        fire(2, 1, 1, 2, 235, 1, 0);
        drain();
        fire(2, 1, 1, 5, 236, 0, 0);
        drain();

        // frame_int held high for 10 cycles -> one edge, one update
        do_reset();
        fire(0, 10, 1, 124, 235, 0, 0);
        drain();
        chk("fc_held", int'(fc[0]), 1);

        // Second edge two cycles after the first lands in CALC_Y
        do_reset();
        exp_q.push_back('{0, 124, 235, 0, 0, cyc + 3});
        fi[0] = 1'b1;
        #1;
        chk("ovr_idle_edge", int'(ovr[0]), 0);
        step();
        fi[0] = 1'b0;
        step();
        fi[0] = 1'b1;
        #1;
        chk("ovr_busy_edge", int'(ovr[0]), 1);
        step();
        fi[0] = 1'b0;
        drain();
        chk("fc_overrun", int'(fc[0]), 2);

        // enable=0 freezes position but frames are still counted
        do_reset();
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            fire(0, 1, 0, 0, 0, 0, 0);
            repeat (2) step();
        end
        drain();
        chk("frozen_x",  int'(ox[0]), 123);
        chk("frozen_y",  int'(oy[0]), 234);
        chk("frozen_fc", int'(fc[0]), 3);
        enable = 1'b1;

        // cfg dx=-128 with an edge: clamped to -127, 123-127=-4 reflects to 4, dx becomes +127
        do_reset();
        cfg_dx = 8'h80;
        cfg_dy = 8'd1;
        cwe[0] = 1'b1;
        exp_q.push_back('{0, 4, 235, 1, 0, cyc + 3});
        fi[0] = 1'b1;
        step();
        cwe[0] = 1'b0;
        fi[0]  = 1'b0;
        drain();
        // Config written mid-update is held until IDLE and used by the following frame
        fire(0, 1, 1, 131, 236, 0, 0);
        cfg(0, 8'd5, 8'd2);
        drain();
        fire(0, 1, 1, 136, 238, 0, 0);
        drain();

        // Reset while in CALC_Y aborts the update
        do_reset();
        cfg(0, 8'd7, 8'd7);
        fi[0] = 1'b1;
        step();
        fi[0] = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_x",  int'(ox[0]), 123);
        chk("abort_y",  int'(oy[0]), 234);
        chk("abort_ud", int'(ud[0]), 0);
        chk("abort_fc", int'(fc[0]), 0);
        repeat (3) step();
        fire(0, 1, 1, 124, 235, 0, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
